// File: rtl/csa_operand_sequencer.sv
// Operand sequencer for a three-input carry-save adder: collects three
// beats, holds them on num1..num3, captures the sum and hands it downstream.
module csa_operand_sequencer #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         abort,
    output logic [N-1:0] num1,
    output logic [N-1:0] num2,
    output logic [N-1:0] num3,
    input  logic [N+1:0] csa_result,
    output logic [N+1:0] sum_out,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [7:0]   group_count
);

    localparam logic [2:0] S_A    = 3'd0;
    localparam logic [2:0] S_B    = 3'd1;
    localparam logic [2:0] S_C    = 3'd2;
    localparam logic [2:0] S_EVAL = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    logic [2:0] state;
    logic       xfer;

    assign in_ready = (state == S_A) || (state == S_B) || (state == S_C);
    assign xfer     = in_valid && in_ready && !abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_A;
            num1        <= '0;
            num2        <= '0;
            num3        <= '0;
            sum_out     <= '0;
            out_valid   <= 1'b0;
            group_count <= 8'd0;
        end else begin
            unique case (state)
                S_A: begin
                    if (xfer) begin
                        num1  <= in_data;
                        state <= S_B;
                    end
                end
                S_B: begin
                    if (abort) begin
                        state <= S_A;
                    end else if (xfer) begin
                        num2  <= in_data;
                        state <= S_C;
                    end
                end
                S_C: begin
                    if (abort) begin
                        state <= S_A;
                    end else if (xfer) begin
                        num3  <= in_data;
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    // Operands have been stable for a full cycle here.
                    sum_out   <= csa_result;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        group_count <= group_count + 8'd1;
                        state       <= S_A;
                    end
                end
                default: begin
                    state <= S_A;
                end
            endcase
        end
    end

endmodule
